// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, no-write-allocate cache with a blocking lookup FSM.
// Optional hit/miss counters are compiled in when CACHE_STATS_EN is defined.
module set_assoc_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int SETS   = 16,
    parameter int WAYS   = 2,
    parameter int WORDS  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw_n,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int OFF_W   = $clog2(WORDS);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_FILL,
        S_WRITE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS][WORDS];
    logic [WAY_W-1:0]  r_rr    [SETS];

    logic [ADDR_W-1:0] r_addr;
    logic              r_rw_n;
    logic [DATA_W-1:0] r_wdata;

    logic [WAY_W-1:0]  r_victim;
    logic              r_victim_valid;
    logic [OFF_W-1:0]  r_k;
    logic              r_cmp_hit;

    logic              r_resp_valid;
    logic              r_resp_hit;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [OFF_W-1:0]   w_off;
    logic [OFF_W-1:0]   w_k_next;
    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_has_inv;
    logic [WAY_W-1:0]   w_inv_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_mem_done;

    assign w_tag      = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx      = r_addr[OFF_W +: INDEX_W];
    assign w_off      = r_addr[OFF_W-1:0];
    assign w_k_next   = r_k + 1'b1;
    assign w_mem_done = r_mem_req & mem_ack;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_rdata = r_resp_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    // Lookup of the captured request; descending scan leaves the lowest matching/invalid way.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
        w_victim = w_has_inv ? w_inv_way : r_rr[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (!r_rw_n) begin
                    w_next = S_WRITE;
                end else if (w_hit) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                if (w_mem_done && (r_k == OFF_W'(WORDS - 1))) begin
                    w_next = S_RESP;
                end
            end
            S_WRITE: begin
                if (w_mem_done) begin
                    w_next = S_IDLE;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Line storage is not reset; only valid bits and pointers are, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
            r_addr         <= '0;
            r_rw_n         <= 1'b0;
            r_wdata        <= '0;
            r_victim       <= '0;
            r_victim_valid <= 1'b0;
            r_k            <= '0;
            r_cmp_hit      <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_rdata   <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_rw_n  <= req_rw_n;
                        r_wdata <= req_wdata;
                    end
                end
                S_COMPARE: begin
                    if (!r_rw_n) begin
                        if (w_hit) begin
                            r_data[w_idx][w_hit_way][w_off] <= r_wdata;
                        end
                        r_cmp_hit   <= w_hit;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                    end else if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_rdata <= r_data[w_idx][w_hit_way][w_off];
                    end else begin
                        r_victim                <= w_victim;
                        r_victim_valid          <= ~w_has_inv;
                        r_valid[w_idx][w_victim] <= 1'b0;
                        r_k                     <= '0;
                        r_mem_req               <= 1'b1;
                        r_mem_we                <= 1'b0;
                        r_mem_addr              <= {w_tag, w_idx, OFF_W'(0)};
                    end
                end
                S_FILL: begin
                    // Request stays high across words; each ack moves the address to the next word.
                    if (w_mem_done) begin
                        r_data[w_idx][r_victim][r_k] <= mem_rdata;
                        if (r_k == w_off) begin
                            r_resp_rdata <= mem_rdata;
                        end
                        if (r_k == OFF_W'(WORDS - 1)) begin
                            r_mem_req                <= 1'b0;
                            r_tag[w_idx][r_victim]   <= w_tag;
                            r_valid[w_idx][r_victim] <= 1'b1;
                            if (r_victim_valid) begin
                                r_rr[w_idx] <= (r_rr[w_idx] == WAY_W'(WAYS - 1)) ?
                                               '0 : r_rr[w_idx] + 1'b1;
                            end
                            r_resp_valid <= 1'b1;
                            r_resp_hit   <= 1'b0;
                        end else begin
                            r_k        <= w_k_next;
                            r_mem_addr <= {w_tag, w_idx, w_k_next};
                        end
                    end
                end
                S_WRITE: begin
                    if (w_mem_done) begin
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= r_cmp_hit;
                        r_resp_rdata <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;

    // Every lookup, read or write, counts once; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (r_state == S_COMPARE) begin
            if (w_hit) begin
                if (r_stat_hits != '1) begin
                    r_stat_hits <= r_stat_hits + 32'd1;
                end
            end else begin
                if (r_stat_misses != '1) begin
                    r_stat_misses <= r_stat_misses + 32'd1;
                end
            end
        end
    end
`endif

endmodule
